// File: rtl/instr_encoder_loader_pkg.sv
// pa_riscv: shared RISC-V definitions for the decoder and the program loader.
//   instrFormat_t   - instruction format selector (R, I, S, B)
//   OPCODE_*        - 7-bit major opcodes, also used by the decoder
//   encoderState_t  - program-loader FSM state
//   immOutOfRange() - detects an immediate that the chosen format cannot hold
package pa_riscv;

    typedef enum logic [1:0] {
        R = 2'd0,
        I = 2'd1,
        S = 2'd2,
        B = 2'd3
    } instrFormat_t;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } encoderState_t;

    // I/S immediates must be 12-bit signed (bit 12 is a pure sign copy);
    // branch offsets must be halfword aligned.
    function automatic logic immOutOfRange(input instrFormat_t format, input logic [12:0] imm);
        logic bad;
        case (format)
            I, S:    bad = imm[12] ^ imm[11];
            B:       bad = imm[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_encoder.sv
// instr_encoder: purely combinational packing of RISC-V fields into a 32-bit
// instruction word. Reusable on its own by testbenches.
//   format     - R, I, S or B
//   rd/rs1/rs2 - register indices (unused ones per format are ignored)
//   funct3     - funct3 field
//   funct7bit5 - bit 30 of R-type words
//   imm        - 13-bit immediate; I/S use [11:0], B uses [12:1]
//   word       - packed instruction
module instr_encoder
    import pa_riscv::*;
(
    input  instrFormat_t format,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [2:0]   funct3,
    input  logic         funct7bit5,
    input  logic [12:0]  imm,
    output logic [31:0]  word
);

    // Field packing per format.
    always_comb begin
        word = 32'd0;
        case (format)
            R:       word = {1'b0, funct7bit5, 5'b00000, rs2, rs1, funct3, rd, OPCODE_R};
            I:       word = {imm[11:0], rs1, funct3, rd, OPCODE_LOAD};
            S:       word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPCODE_STORE};
            B:       word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPCODE_BRANCH};
            default: word = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: streams encoded instruction words into the core's
// instruction memory at consecutive word addresses starting at 0.
// Optional feature macro: INSTR_ENCODER_IMM_CHECK_EN (immediate range check
// driving o_immErr; without it o_immErr stays 0).
// Ports:
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_start             - open a session (honoured in IDLE/DONE only)
//   i_valid/o_ready     - field handshake; o_ready depends on state only
//   i_last              - marks the final instruction of the session
//   i_format..i_imm     - instruction fields
//   o_memWriteEn/Addr/WriteData - registered memory write port
//   o_count             - words written this session
//   o_done              - session finished, held until next i_start
//   o_overflow          - memory filled before i_last, sticky
//   o_immErr            - bad immediate seen, sticky
module instr_encoder_loader
    import pa_riscv::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_last,
    input  instrFormat_t      i_format,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7bit5,
    input  logic [12:0]       i_imm,
    output logic              o_memWriteEn,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [31:0]       o_memWriteData,
    output logic [ADDR_W:0]   o_count,
    output logic              o_done,
    output logic              o_overflow,
    output logic              o_immErr
);

    // Word count at which the next accepted word occupies the final slot.
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W + 1)'(1);

    encoderState_t     state_r;
    encoderState_t     nextState_s;
    logic [ADDR_W:0]   count_r;
    logic              memWriteEn_r;
    logic [ADDR_W-1:0] memAddr_r;
    logic [31:0]       memWriteData_r;
    logic              done_r;
    logic              overflow_r;
    logic              immErr_r;

    logic              ready_s;
    logic              accept_s;
    logic              lastSlot_s;
    logic              startClear_s;
    logic              immHit_s;
    logic [31:0]       word_s;

    instr_encoder uEncoder (
        .format     (i_format),
        .rd         (i_rd),
        .rs1        (i_rs1),
        .rs2        (i_rs2),
        .funct3     (i_funct3),
        .funct7bit5 (i_funct7bit5),
        .imm        (i_imm),
        .word       (word_s)
    );

    // Handshake qualifiers; ready is a pure function of state.
    always_comb begin
        ready_s    = (state_r == LOAD);
        accept_s   = ready_s & i_valid;
        lastSlot_s = (count_r == LAST_SLOT);
    end

    // Immediate check, compiled in only when the feature is enabled.
    always_comb begin
`ifdef INSTR_ENCODER_IMM_CHECK_EN
        immHit_s = accept_s & immOutOfRange(i_format, i_imm);
`else
        immHit_s = 1'b0;
`endif
    end

    // Next-state logic; startClear_s marks the edge that opens a session.
    always_comb begin
        nextState_s  = state_r;
        startClear_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (i_start) begin
                    nextState_s  = LOAD;
                    startClear_s = 1'b1;
                end else begin
                    nextState_s  = state_r;
                end
            end
            LOAD: begin
                // The final slot closes the session even without i_last.
                if (accept_s && (i_last || lastSlot_s)) begin
                    nextState_s = FLUSH;
                end else begin
                    nextState_s = LOAD;
                end
            end
            FLUSH:   nextState_s = DONE;
            default: nextState_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Write port, counter and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            memWriteEn_r   <= 1'b0;
            memAddr_r      <= '0;
            memWriteData_r <= 32'd0;
            count_r        <= '0;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
            immErr_r       <= 1'b0;
        end else begin
            memWriteEn_r <= accept_s;
            if (startClear_s) begin
                count_r    <= '0;
                done_r     <= 1'b0;
                overflow_r <= 1'b0;
                immErr_r   <= 1'b0;
            end else begin
                if (accept_s) begin
                    // count_r never exceeds DEPTH-1 while in LOAD, so the
                    // low bits are always a valid word address.
                    memAddr_r      <= count_r[ADDR_W-1:0];
                    memWriteData_r <= word_s;
                    count_r        <= count_r + COUNT_ONE;
                end
                if (accept_s && lastSlot_s && !i_last) begin
                    overflow_r <= 1'b1;
                end
                if (immHit_s) begin
                    immErr_r <= 1'b1;
                end
                if (state_r == FLUSH) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

    // Output drive.
    always_comb begin
        o_ready        = ready_s;
        o_memWriteEn   = memWriteEn_r;
        o_memAddr      = memAddr_r;
        o_memWriteData = memWriteData_r;
        o_count        = count_r;
        o_done         = done_r;
        o_overflow     = overflow_r;
        o_immErr       = immErr_r;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
`ifdef INSTR_ENCODER_IMM_CHECK_EN
    localparam bit IMM_CHK = 1'b1;
`else
    localparam bit IMM_CHK = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   valid;
    logic                   ready;
    logic                   last;
    pa_riscv::instrFormat_t format;
    logic [4:0]             rd;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [2:0]             funct3;
    logic                   f7b5;
    logic [12:0]            imm;
    logic                   memWe;
    logic [ADDR_W-1:0]      memAddr;
    logic [31:0]            memData;
    logic [ADDR_W:0]        count;
    logic                   done;
    logic                   overflow;
    logic                   immErr;

    instr_encoder_loader #(.DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_last         (last),
        .i_format       (format),
        .i_rd           (rd),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_funct3       (funct3),
        .i_funct7bit5   (f7b5),
        .i_imm          (imm),
        .o_memWriteEn   (memWe),
        .o_memAddr      (memAddr),
        .o_memWriteData (memData),
        .o_count        (count),
        .o_done         (done),
        .o_overflow     (overflow),
        .o_immErr       (immErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: session phase, words written, sticky flags.
    localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2, P_DONE = 3;
    int mPhase = P_IDLE;
    int mCount = 0;
    bit mDone  = 1'b0;
    bit mOvf   = 1'b0;
    bit mImm   = 1'b0;

    // Instruction word built from the field layout with plain arithmetic.
    function automatic logic [31:0] refEnc(input logic [1:0] fm, input int unsigned rdV,
                                           input int unsigned rs1V, input int unsigned rs2V,
                                           input int unsigned f3V, input int unsigned f7V,
                                           input int unsigned immV);
        int unsigned w;
        int unsigned common;
        common = (rs1V << 15) | (f3V << 12);
        if (fm == pa_riscv::R) begin
            w = (f7V << 30) | (rs2V << 20) | common | (rdV << 7) | 32'h33;
        end else if (fm == pa_riscv::I) begin
            w = ((immV & 32'hFFF) << 20) | common | (rdV << 7) | 32'h03;
        end else if (fm == pa_riscv::S) begin
            w = (((immV >> 5) & 32'h7F) << 25) | (rs2V << 20) | common
              | ((immV & 32'h1F) << 7) | 32'h23;
        end else begin
            w = (((immV >> 12) & 32'h1) << 31) | (((immV >> 5) & 32'h3F) << 25)
              | (rs2V << 20) | common | (((immV >> 1) & 32'hF) << 8)
              | (((immV >> 11) & 32'h1) << 7) | 32'h63;
        end
        return w;
    endfunction

    function automatic bit refImmBad(input logic [1:0] fm, input logic [12:0] immV);
        int v;
        v = int'(immV);
        if (v >= 4096) v = v - 8192;
        if (fm == pa_riscv::B) return (v % 2) != 0;
        if (fm == pa_riscv::R) return 1'b0;
        return (v < -2048) || (v > 2047);
    endfunction

    // One clock: drive inputs, advance the model, check every output.
    task automatic step(input bit rs_, input bit st, input bit va, input bit la,
                        input logic [1:0] fm, input logic [4:0] rdV, input logic [4:0] rs1V,
                        input logic [4:0] rs2V, input logic [2:0] f3V, input bit f7V,
                        input logic [12:0] immV);
        bit          acc;
        int          expAddr;
        logic [31:0] expWord;
        @(negedge clk);
        rst    = rs_;
        start  = st;
        valid  = va;
        last   = la;
        format = pa_riscv::instrFormat_t'(fm);
        rd     = rdV;
        rs1    = rs1V;
        rs2    = rs2V;
        funct3 = f3V;
        f7b5   = f7V;
        imm    = immV;
        acc     = 1'b0;
        expAddr = mCount;
        expWord = refEnc(fm, rdV, rs1V, rs2V, f3V, f7V, immV);
        if (rs_) begin
            mPhase = P_IDLE; mCount = 0; mDone = 0; mOvf = 0; mImm = 0;
        end else if (mPhase == P_IDLE || mPhase == P_DONE) begin
            if (st) begin
                mPhase = P_LOAD; mCount = 0; mDone = 0; mOvf = 0; mImm = 0;
            end
        end else if (mPhase == P_LOAD) begin
            if (va) begin
                acc = 1'b1;
                mCount++;
                if (IMM_CHK && refImmBad(fm, immV)) mImm = 1'b1;
                if (la) begin
                    mPhase = P_FLUSH;
                end else if (mCount == DEPTH) begin
                    mPhase = P_FLUSH;
                    mOvf   = 1'b1;
                end
            end
        end else begin
            mPhase = P_DONE;
            mDone  = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("writeEn", 32'(memWe), 32'(acc));
        if (acc) begin
            chk("addr", 32'(memAddr), 32'(expAddr));
            chk("data", memData, expWord);
        end
        if (rs_) begin
            chk("rstAddr", 32'(memAddr), 32'd0);
            chk("rstData", memData, 32'd0);
        end
        chk("ready", 32'(ready), 32'(mPhase == P_LOAD));
        chk("count", 32'(count), 32'(mCount));
        chk("done", 32'(done), 32'(mDone));
        chk("overflow", 32'(overflow), 32'(mOvf));
        chk("immErr", 32'(immErr), 32'(mImm));
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
    endtask

    typedef struct {
        bit          st;
        bit          va;
        bit          la;
        logic [1:0]  fm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        bit          f7;
        logic [12:0] imm;
        bit          expWe;
        int          expAddr;
        logic [31:0] expWord;
    } vec_t;

    vec_t tbl[10];

    initial begin
        rst = 1'b0; start = 1'b0; valid = 1'b0; last = 1'b0;
        format = pa_riscv::R; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; f7b5 = 1'b0; imm = 13'd0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, pa_riscv::R, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0,      1'b0, 0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, pa_riscv::I, 5'd5, 5'd1, 5'd0, 3'd2, 1'b0, 13'd8,      1'b1, 0, 32'h0080A283};
        tbl[2] = '{1'b0, 1'b1, 1'b0, pa_riscv::S, 5'd0, 5'd2, 5'd6, 3'd2, 1'b0, 13'd12,     1'b1, 1, 32'h00612623};
        tbl[3] = '{1'b0, 1'b1, 1'b1, pa_riscv::R, 5'd7, 5'd5, 5'd6, 3'd0, 1'b1, 13'd0,      1'b1, 2, 32'h406283B3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, pa_riscv::R, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd0,      1'b0, 0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, pa_riscv::R, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0,      1'b0, 0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, pa_riscv::R, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0,      1'b0, 0, 32'h0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, pa_riscv::B, 5'd0, 5'd5, 5'd6, 3'd0, 1'b0, 13'h1FFC,   1'b1, 0, 32'hFE628EE3};
        tbl[8] = '{1'b0, 1'b0, 1'b0, pa_riscv::R, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0,      1'b0, 0, 32'h0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, pa_riscv::R, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0,      1'b0, 0, 32'h0};

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        nop();

        // Known encodings, back-to-back timing, last handling, done timing.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].st, tbl[i].va, tbl[i].la, tbl[i].fm, tbl[i].rd, tbl[i].rs1,
                 tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm);
            chk("tblWe", 32'(memWe), 32'(tbl[i].expWe));
            if (tbl[i].expWe) begin
                chk("tblAddr", 32'(memAddr), 32'(tbl[i].expAddr));
                chk("tblWord", memData, tbl[i].expWord);
            end
        end
        chk("bCount", 32'(count), 32'd1);

        // Overflow: five valid words, no last, DEPTH=4.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, pa_riscv::R, 5'(i + 1), 5'd3, 5'd4, 3'd1, 1'b0, 13'd0);
        end
        nop();
        chk("ovfFlag", 32'(overflow), 32'd1);
        chk("ovfDone", 32'(done), 32'd1);
        chk("ovfCount", 32'(count), 32'd4);

        // Start while loading is ignored; the next word lands at address 1.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, pa_riscv::I, 5'd2, 5'd3, 5'd0, 3'd0, 1'b0, 13'd100);
        step(1'b0, 1'b1, 1'b1, 1'b1, pa_riscv::S, 5'd0, 5'd3, 5'd9, 3'd1, 1'b0, 13'h1F00);
        chk("ignStartAddr", 32'(memAddr), 32'd1);
        nop();
        nop();

        // Reset mid-session after two writes, then restart at address 0.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, pa_riscv::R, 5'd1, 5'd2, 5'd3, 3'd4, 1'b1, 13'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, pa_riscv::R, 5'd4, 5'd5, 5'd6, 3'd7, 1'b0, 13'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, pa_riscv::R, 5'd4, 5'd5, 5'd6, 3'd7, 1'b0, 13'd0);
        chk("rstReady", 32'(ready), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, pa_riscv::I, 5'd8, 5'd9, 5'd0, 3'd3, 1'b0, 13'd1);
        chk("restartAddr", 32'(memAddr), 32'd0);
        nop();
        nop();

        // Out-of-range I immediate: word is still written, truncated.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 13'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, pa_riscv::I, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 13'h0800);
        chk("immField", 32'(memData[31:20]), 32'h800);
        chk("immErrFlag", 32'(immErr), 32'(IMM_CHK));
        nop();
        nop();

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 250) == 0, ($urandom % 4) == 0, ($urandom % 4) != 0,
                 ($urandom % 6) == 0, 2'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 3'($urandom), 1'($urandom), 13'($urandom));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Streams program words into the single-cycle core's instruction memory, and is the encoding counterpart of the instruction decoder. It accepts RISC-V instruction fields (format, register indices, funct3, funct7 bit 5, immediate) over a valid/ready handshake. It packs them into 32-bit R/I/S/B instruction words and writes them to consecutive word addresses from 0. It is used by testbenches and boot logic to load programs before the core is released.

Parameters:
DEPTH, 64, instruction memory size in 32-bit words; minimum 2.
ADDR_W, $clog2(DEPTH), width of the word address and count.

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous active-high reset.
i_start  input  1  begin a load session at word address 0. Sampled in IDLE and DONE only.
i_valid  input  1  instruction fields valid.
o_ready  output  1  block accepts fields this cycle.
i_last  input  1  accompanying instruction is the final one of the session.
i_format  input  2  instruction format, typed pa_riscv::instrFormat_t: R, I, S, B.
i_rd  input  5  destination register index (R, I).
i_rs1  input  5  source register 1 index (R, I, S, B).
i_rs2  input  5  source register 2 index (R, S, B).
i_funct3  input  3  funct3 field.
i_funct7bit5  input  1  bit 30 of R-type words.
i_imm  input  13  signed immediate. I/S use bits [11:0]; B uses bits [12:1].
o_memWriteEn  output  1  instruction memory write strobe.
o_memAddr  output  ADDR_W  word address of the write.
o_memWriteData  output  32  encoded instruction word.
o_count  output  ADDR_W+1  number of words written in the current session.
o_done  output  1  session complete; held high until the next i_start.
o_overflow  output  1  memory filled before i_last; sticky until i_start.
o_immErr  output  1  immediate out of range; sticky until i_start (see Optional Feature).

Behaviour:
- Reset (synchronous, overrides everything, also mid-session):
  - State goes to IDLE.
  - All outputs 0, including address counter and o_count.
- Opcode mapping, from package constants:
  - R = 0110011, I = 0000011 (load), S = 0100011, B = 1100011.
- Encoding:
  - R: {1'b0, funct7bit5, 5'b0, rs2, rs1, funct3, rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - Fields unused by a format are ignored.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: i_start -> LOAD; clears address, o_count, o_done, o_overflow, o_immErr.
  - LOAD: o_ready = 1. The handshake fires on i_valid && o_ready.
    - Accept with i_last: -> FLUSH.
    - Accept at address DEPTH-1 without i_last: -> FLUSH, and o_overflow is set in the same edge.
    - Otherwise stay in LOAD.
  - FLUSH: o_ready = 0, one cycle -> DONE.
  - DONE: o_done = 1. i_start -> LOAD with all clears as in IDLE.
  - i_start in LOAD or FLUSH is ignored.
- Write latency:
  - Fields accepted at edge N appear at N+1 as o_memWriteEn = 1, o_memAddr = current address, o_memWriteData = encoded word.
  - Address and o_count increment at that same edge.
  - o_memWriteEn is a single-cycle pulse per accepted word.
  - Throughput is 1 word/cycle; no bubbles while i_valid stays high.
- o_ready is combinational from state only, never from i_valid.
- o_done rises the cycle after the final write strobe.
- Address never wraps. A session holds at most DEPTH words.
- o_count reaches DEPTH exactly on overflow.

Optional Feature:
Macro: INSTR_ENCODER_IMM_CHECK_EN.
- Defined: o_immErr is set (sticky) on accept when either condition holds:
  - I/S: i_imm[12] != i_imm[11], i.e. the value does not fit in 12-bit signed.
  - B: i_imm[0] = 1, i.e. the offset is misaligned.
  - The word is still written, truncated; the session continues.
- Undefined: o_immErr is tied 0; immediates are silently truncated.

Decomposition:
- pa_riscv gains:
  - the instrFormat_t enum {R, I, S, B};
  - the 7-bit opcode constants reused by the decoder;
  - an encoderState_t enum.
- Sub-module instr_encoder: purely combinational field-to-word packing, reusable by testbenches.
- The top level holds the FSM, counters and output registers.

Test Plan:
- I: rd=5, rs1=1, funct3=2, imm=8 -> word 0x0080A283 at addr 0, strobe one cycle after accept.
- S: rs2=6, rs1=2, funct3=2, imm=12, then R: rd=7, rs1=5, rs2=6, funct3=0, funct7bit5=1 -> 0x00612623 @1, then 0x406283B3 @2 in back-to-back cycles.
- B with i_last: rs1=5, rs2=6, funct3=0, imm=-4 -> 0xFE628EE3; o_ready low next cycle; o_done high the cycle after the strobe; o_count=1.
- DEPTH=4, 5 valid words with no i_last -> 4 writes to addr 0..3; o_overflow=1, o_done=1, o_count=4; 5th word never accepted.
- Assert i_rst in mid-session after 2 writes -> outputs zero, IDLE next cycle. Then i_start plus 1 word -> write at addr 0.
- With INSTR_ENCODER_IMM_CHECK_EN: I imm=0x0800 -> o_immErr=1, word written with imm field 0x800. Without the macro -> o_immErr=0.
